// File: rtl/dvi_layer_mixer_if.sv
// Bundles the pixel timing, configuration, memory and colour signals of dvi_layer_mixer.
// The master side drives pixels, configuration and memory data; the slave side is the mixer.
interface dvi_layer_mixer_if #(
    parameter int X_POS_W  = 10,
    parameter int Y_POS_W  = 10,
    parameter int COLOR_W  = 8,
    parameter int N_LAYERS = 2,
    parameter int IMG_AW   = 16,
    parameter int SCALE_W  = 2
) ();
    localparam int LAYER_W = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;
    localparam int WL_W    = $clog2(IMG_AW + 1);

    logic [X_POS_W-1:0]          pixel_x_i;
    logic [Y_POS_W-1:0]          pixel_y_i;
    logic                        hsync_i;
    logic                        vsync_i;
    logic                        de_i;
    logic [3*COLOR_W-1:0]        bg_color_i;
    logic                        cfg_we_i;
    logic [LAYER_W-1:0]          cfg_layer_i;
    logic                        cfg_en_i;
    logic                        cfg_mode_i;
    logic [X_POS_W-1:0]          cfg_x_i;
    logic [Y_POS_W-1:0]          cfg_y_i;
    logic [WL_W-1:0]             cfg_wlog2_i;
    logic [Y_POS_W-1:0]          cfg_h_i;
    logic [SCALE_W-1:0]          cfg_scale_i;
    logic [N_LAYERS-1:0]         cfg_pending_o;
    logic [N_LAYERS*IMG_AW-1:0]  mem_addr_o;
    logic [N_LAYERS*COLOR_W-1:0] mem_data_i;
    logic [COLOR_W-1:0]          red_o;
    logic [COLOR_W-1:0]          green_o;
    logic [COLOR_W-1:0]          blue_o;
    logic                        hsync_o;
    logic                        vsync_o;
    logic                        de_o;

    modport master (
        output pixel_x_i, pixel_y_i, hsync_i, vsync_i, de_i, bg_color_i,
        output cfg_we_i, cfg_layer_i, cfg_en_i, cfg_mode_i, cfg_x_i, cfg_y_i,
        output cfg_wlog2_i, cfg_h_i, cfg_scale_i, mem_data_i,
        input  cfg_pending_o, mem_addr_o, red_o, green_o, blue_o, hsync_o, vsync_o, de_o
    );

    modport slave (
        input  pixel_x_i, pixel_y_i, hsync_i, vsync_i, de_i, bg_color_i,
        input  cfg_we_i, cfg_layer_i, cfg_en_i, cfg_mode_i, cfg_x_i, cfg_y_i,
        input  cfg_wlog2_i, cfg_h_i, cfg_scale_i, mem_data_i,
        output cfg_pending_o, mem_addr_o, red_o, green_o, blue_o, hsync_o, vsync_o, de_o
    );
endinterface

// File: rtl/dvi_layer_mixer.sv
// Three-stage compositor: hit test/address, memory read, colour select over a background.
// Layer configuration is double-buffered and swapped in on the vsync rising edge.
module dvi_layer_mixer #(
    parameter int X_POS_W  = 10,
    parameter int Y_POS_W  = 10,
    parameter int COLOR_W  = 8,
    parameter int N_LAYERS = 2,
    parameter int IMG_AW   = 16,
    parameter int SCALE_W  = 2
) (
    input logic clk_i,
    input logic rst_ni,
    dvi_layer_mixer_if.slave bus
);
    localparam int LAYER_W = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;
    localparam int WL_W    = $clog2(IMG_AW + 1);
    // Wide enough for x0 + (2^wlog2 << s) and (sy << wlog2) without wrapping.
    localparam int EW      = 64;

    logic [N_LAYERS-1:0] sh_en, sh_mode, act_en, act_mode, pending;
    logic [X_POS_W-1:0]  sh_x [N_LAYERS];
    logic [X_POS_W-1:0]  act_x [N_LAYERS];
    logic [Y_POS_W-1:0]  sh_y [N_LAYERS];
    logic [Y_POS_W-1:0]  act_y [N_LAYERS];
    logic [WL_W-1:0]     sh_wl [N_LAYERS];
    logic [WL_W-1:0]     act_wl [N_LAYERS];
    logic [Y_POS_W-1:0]  sh_h [N_LAYERS];
    logic [Y_POS_W-1:0]  act_h [N_LAYERS];
    logic [SCALE_W-1:0]  sh_s [N_LAYERS];
    logic [SCALE_W-1:0]  act_s [N_LAYERS];
    logic                vsync_q;
    logic                frame_start;

    assign frame_start       = bus.vsync_i && !vsync_q;
    assign bus.cfg_pending_o = pending;

    // Non-blocking order gives the transfer the pre-write shadow when both happen together.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vsync_q  <= 1'b0;
            sh_en    <= '0;
            sh_mode  <= '0;
            act_en   <= '0;
            act_mode <= '0;
            pending  <= '0;
            for (int l = 0; l < N_LAYERS; l++) begin
                sh_x[l]  <= '0;
                act_x[l] <= '0;
                sh_y[l]  <= '0;
                act_y[l] <= '0;
                sh_wl[l] <= '0;
                act_wl[l] <= '0;
                sh_h[l]  <= '0;
                act_h[l] <= '0;
                sh_s[l]  <= '0;
                act_s[l] <= '0;
            end
        end else begin
            vsync_q <= bus.vsync_i;
            for (int l = 0; l < N_LAYERS; l++) begin
                if (frame_start && pending[l]) begin
                    act_en[l]   <= sh_en[l];
                    act_mode[l] <= sh_mode[l];
                    act_x[l]    <= sh_x[l];
                    act_y[l]    <= sh_y[l];
                    act_wl[l]   <= sh_wl[l];
                    act_h[l]    <= sh_h[l];
                    act_s[l]    <= sh_s[l];
                    pending[l]  <= 1'b0;
                end
                if (bus.cfg_we_i && bus.cfg_layer_i == LAYER_W'(l)) begin
                    sh_en[l]   <= bus.cfg_en_i;
                    sh_mode[l] <= bus.cfg_mode_i;
                    sh_x[l]    <= bus.cfg_x_i;
                    sh_y[l]    <= bus.cfg_y_i;
                    sh_wl[l]   <= bus.cfg_wlog2_i;
                    sh_h[l]    <= bus.cfg_h_i;
                    sh_s[l]    <= bus.cfg_scale_i;
                    pending[l] <= 1'b1;
                end
            end
        end
    end

    logic [N_LAYERS-1:0]             hit;
    logic [N_LAYERS-1:0][IMG_AW-1:0] addr_nxt;
    logic [EW-1:0]                   px_w, py_w;

    assign px_w = EW'(bus.pixel_x_i);
    assign py_w = EW'(bus.pixel_y_i);

    for (genvar l = 0; l < N_LAYERS; l++) begin : g_layer
        logic [EW-1:0] x0_w, y0_w, x_end, y_end, dx, dy, sx, sy;

        assign x0_w  = EW'(act_x[l]);
        assign y0_w  = EW'(act_y[l]);
        assign x_end = x0_w + ((EW'(1) << act_wl[l]) << act_s[l]);
        assign y_end = y0_w + (EW'(act_h[l]) << act_s[l]);
        assign dx    = px_w - x0_w;
        assign dy    = py_w - y0_w;
        assign sx    = dx >> act_s[l];
        assign sy    = dy >> act_s[l];
        assign hit[l] = act_en[l] && (px_w >= x0_w) && (px_w < x_end)
                                  && (py_w >= y0_w) && (py_w < y_end);
        assign addr_nxt[l] = IMG_AW'((sy << act_wl[l]) | sx);
    end

    logic [N_LAYERS-1:0]             s1_hit, s1_mode, s2_hit, s2_mode;
    logic [N_LAYERS-1:0][IMG_AW-1:0] mem_addr_q;
    logic                            s1_hs, s1_vs, s1_de, s2_hs, s2_vs, s2_de;
    logic [3*COLOR_W-1:0]            rgb_nxt, rgb_q;
    logic                            hs_q, vs_q, de_q;

    assign bus.mem_addr_o = mem_addr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_hit     <= '0;
            s1_mode    <= '0;
            mem_addr_q <= '0;
            s1_hs      <= 1'b0;
            s1_vs      <= 1'b0;
            s1_de      <= 1'b0;
            s2_hit     <= '0;
            s2_mode    <= '0;
            s2_hs      <= 1'b0;
            s2_vs      <= 1'b0;
            s2_de      <= 1'b0;
            rgb_q      <= '0;
            hs_q       <= 1'b0;
            vs_q       <= 1'b0;
            de_q       <= 1'b0;
        end else begin
            s1_hit  <= hit;
            s1_mode <= act_mode;
            for (int l = 0; l < N_LAYERS; l++) begin
                if (hit[l]) mem_addr_q[l] <= addr_nxt[l];
            end
            s1_hs   <= bus.hsync_i;
            s1_vs   <= bus.vsync_i;
            s1_de   <= bus.de_i;
            s2_hit  <= s1_hit;
            s2_mode <= s1_mode;
            s2_hs   <= s1_hs;
            s2_vs   <= s1_vs;
            s2_de   <= s1_de;
            rgb_q   <= rgb_nxt;
            hs_q    <= s2_hs;
            vs_q    <= s2_vs;
            de_q    <= s2_de;
        end
    end

    // Higher layer index is scanned later and therefore wins.
    always_comb begin
        rgb_nxt = bus.bg_color_i;
        for (int l = 0; l < N_LAYERS; l++) begin
            if (s2_hit[l]) begin
                if (s2_mode[l]) begin
                    rgb_nxt = bus.mem_data_i[l*COLOR_W] ? '0 : '1;
                end else begin
                    rgb_nxt = {bus.mem_data_i[l*COLOR_W +: COLOR_W],
                               bus.mem_data_i[l*COLOR_W +: COLOR_W],
                               bus.mem_data_i[l*COLOR_W +: COLOR_W]};
                end
            end
        end
        if (!s2_de) rgb_nxt = '0;
    end

    assign bus.red_o   = rgb_q[3*COLOR_W-1 -: COLOR_W];
    assign bus.green_o = rgb_q[2*COLOR_W-1 -: COLOR_W];
    assign bus.blue_o  = rgb_q[COLOR_W-1:0];
    assign bus.hsync_o = hs_q;
    assign bus.vsync_o = vs_q;
    assign bus.de_o    = de_q;
endmodule

// File: tb/tb_dvi_layer_mixer.sv
// Directed bench for dvi_layer_mixer: bypass timing, boundaries, scaling, priority,
// double buffering and mid-frame reset, against hand-computed colours and addresses.
module tb_dvi_layer_mixer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int compared = 0;
    int mismatched = 0;
    localparam logic [23:0] BG = 24'h102030;

    always #5 clk = ~clk;

    dvi_layer_mixer_if bus ();
    dvi_layer_mixer dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

    // Layer memories, one-cycle read latency. Layer0: addr[7:0]^5A, layer1: addr[7:0]^F0.
    always @(posedge clk)
        bus.mem_data_i <= {bus.mem_addr_o[23:16] ^ 8'hF0, bus.mem_addr_o[7:0] ^ 8'h5A};

    function automatic logic [23:0] rgb();
        return {bus.red_o, bus.green_o, bus.blue_o};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input int layer, input bit en, input bit mode, input int x,
                             input int y, input int wl, input int h, input int s);
        @(negedge clk);
        bus.cfg_we_i    = 1'b1;
        bus.cfg_layer_i = layer[0];
        bus.cfg_en_i    = en;
        bus.cfg_mode_i  = mode;
        bus.cfg_x_i     = x[9:0];
        bus.cfg_y_i     = y[9:0];
        bus.cfg_wlog2_i = wl[4:0];
        bus.cfg_h_i     = h[9:0];
        bus.cfg_scale_i = s[1:0];
        @(negedge clk);
        bus.cfg_we_i    = 1'b0;
    endtask

    task automatic vs_pulse();
        @(negedge clk);
        bus.vsync_i = 1'b1;
        @(negedge clk);
        bus.vsync_i = 1'b0;
    endtask

    // Drive one pixel and hold it; check the layer address one cycle later and RGB three later.
    task automatic px(input int x, input int y, input int lay, input logic [15:0] eaddr,
                      input logic [23:0] ergb, input string tag);
        @(negedge clk);
        bus.pixel_x_i = x[9:0];
        bus.pixel_y_i = y[9:0];
        bus.de_i      = 1'b1;
        @(posedge clk); #1;
        if (lay == 0) chk({tag, "_addr"}, 32'(bus.mem_addr_o[15:0]), 32'(eaddr));
        else if (lay == 1) chk({tag, "_addr"}, 32'(bus.mem_addr_o[31:16]), 32'(eaddr));
        repeat (2) @(posedge clk);
        #1;
        chk({tag, "_rgb"}, 32'(rgb()), 32'(ergb));
    endtask

    initial begin
        bus.pixel_x_i = '0; bus.pixel_y_i = '0;
        bus.hsync_i = 1'b0; bus.vsync_i = 1'b0; bus.de_i = 1'b1;
        bus.bg_color_i = BG;
        bus.cfg_we_i = 1'b0; bus.cfg_layer_i = '0; bus.cfg_en_i = 1'b0; bus.cfg_mode_i = 1'b0;
        bus.cfg_x_i = '0; bus.cfg_y_i = '0; bus.cfg_wlog2_i = '0; bus.cfg_h_i = '0;
        bus.cfg_scale_i = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rgb", 32'(rgb()), 32'h0);
        chk("rst_de", 32'(bus.de_o), 32'h0);
        chk("rst_pending", 32'(bus.cfg_pending_o), 32'h0);
        chk("rst_addr", bus.mem_addr_o, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Bypass and exact 3-cycle latency of colour, sync and de
        px(0, 0, -1, 16'h0, BG, "bypass");
        @(negedge clk);
        bus.de_i = 1'b0; bus.hsync_i = 1'b1; bus.vsync_i = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        bus.de_i = 1'b1; bus.hsync_i = 1'b0; bus.vsync_i = 1'b0;
        @(posedge clk); #1;
        chk("lat2_rgb", 32'(rgb()), 32'(BG));
        chk("lat2_hs", 32'(bus.hsync_o), 32'h0);
        @(posedge clk); #1;
        chk("lat3_rgb_de0", 32'(rgb()), 32'h0);
        chk("lat3_hs", 32'(bus.hsync_o), 32'h1);
        chk("lat3_vs", 32'(bus.vsync_o), 32'h1);
        chk("lat3_de", 32'(bus.de_o), 32'h0);
        @(posedge clk); #1;
        chk("lat4_rgb", 32'(rgb()), 32'(BG));
        chk("lat4_hs", 32'(bus.hsync_o), 32'h0);

        // Boundaries: layer0 grayscale at (20,20), 256x256, s=0
        cfg_write(0, 1'b1, 1'b0, 20, 20, 8, 256, 0);
        chk("l0_pending", 32'(bus.cfg_pending_o), 32'h1);
        px(20, 20, -1, 16'h0, BG, "l0_not_yet");
        vs_pulse();
        chk("l0_applied", 32'(bus.cfg_pending_o), 32'h0);
        px(20, 20, 0, 16'h0000, 24'h5A5A5A, "b_20_20");
        px(275, 275, 0, 16'hFFFF, 24'hA5A5A5, "b_275_275");
        px(19, 20, -1, 16'h0, BG, "b_19_20");
        px(276, 20, -1, 16'h0, BG, "b_276_20");

        // Scaling: layer1 mono at (360,150), 128x128 source, s=1
        cfg_write(1, 1'b1, 1'b1, 360, 150, 7, 128, 1);
        vs_pulse();
        px(360, 150, 1, 16'h0000, 24'hFFFFFF, "s_360_150");
        px(361, 151, 1, 16'h0000, 24'hFFFFFF, "s_361_151");
        px(362, 150, 1, 16'h0001, 24'h000000, "s_362_150");

        // Priority: layer1 moved over layer0 at (100,100)
        cfg_write(1, 1'b1, 1'b1, 100, 100, 7, 128, 0);
        vs_pulse();
        px(100, 100, 1, 16'h0000, 24'hFFFFFF, "prio_l1");
        cfg_write(1, 1'b0, 1'b1, 100, 100, 7, 128, 0);
        vs_pulse();
        px(100, 100, 0, 16'h5050, 24'h0A0A0A, "prio_l0");

        // Double buffering, including a write landing in the vsync edge cycle
        cfg_write(0, 1'b1, 1'b0, 50, 20, 8, 256, 0);
        chk("db_pending", 32'(bus.cfg_pending_o), 32'h1);
        px(20, 20, 0, 16'h0000, 24'h5A5A5A, "db_old");
        @(negedge clk);
        bus.vsync_i = 1'b1;
        bus.cfg_we_i = 1'b1; bus.cfg_layer_i = 1'b0; bus.cfg_x_i = 10'd20;
        @(negedge clk);
        bus.vsync_i = 1'b0; bus.cfg_we_i = 1'b0;
        chk("edge_pending", 32'(bus.cfg_pending_o), 32'h1);
        px(20, 20, -1, 16'h0, BG, "db_new_20");
        px(50, 20, 0, 16'h0000, 24'h5A5A5A, "db_new_50");
        vs_pulse();
        chk("edge_applied", 32'(bus.cfg_pending_o), 32'h0);
        px(20, 20, 0, 16'h0000, 24'h5A5A5A, "edge_20");

        // Mid-frame reset with a pending write outstanding
        cfg_write(1, 1'b1, 1'b0, 0, 0, 8, 256, 0);
        chk("pre_rst_pending", 32'(bus.cfg_pending_o), 32'h2);
        px(21, 22, 0, 16'h0201, 24'h5B5B5B, "pre_rst");
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rgb", 32'(rgb()), 32'h0);
        chk("mid_rst_de", 32'(bus.de_o), 32'h0);
        chk("mid_rst_addr", bus.mem_addr_o, 32'h0);
        chk("mid_rst_pending", 32'(bus.cfg_pending_o), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        vs_pulse();
        px(21, 22, -1, 16'h0, BG, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/dvi_layer_mixer.md
# dvi_layer_mixer

Parametrised pixel-pipeline compositor for the DVI path. It sits between `dvi_sync` and the three `tmds_encoder` instances. It overlays up to `N_LAYERS` rectangular image layers on a background colour, each with its own position, size, integer upscale and pixel mode. Layer configuration is double-buffered and takes effect only at frame start. Pixel data is fetched from external per-layer memories with fixed 1-cycle read latency, and sync/DE are delayed to stay aligned with the RGB output.

## Interface
- `X_POS_W`, 10, pixel x coordinate width
- `Y_POS_W`, 10, pixel y coordinate width
- `COLOR_W`, 8, bits per colour channel
- `N_LAYERS`, 2, number of layers; higher index has higher priority
- `IMG_AW`, 16, per-layer memory address width
- `SCALE_W`, 2, width of the scale shift field (upscale factor 1 to 2^(2^SCALE_W-1))

Ports:
- `clk_i` in 1: pixel clock, only clock
- `rst_ni` in 1: asynchronous active-low reset
- `pixel_x_i` in X_POS_W: current pixel x
- `pixel_y_i` in Y_POS_W: current pixel y
- `hsync_i`, `vsync_i`, `de_i` in 1 each: timing from `dvi_sync`; vsync is active-high
- `bg_color_i` in 3*COLOR_W: background colour {R,G,B}
- `cfg_we_i` in 1: configuration write strobe
- `cfg_layer_i` in $clog2(N_LAYERS): target layer
- `cfg_en_i` in 1: layer enable
- `cfg_mode_i` in 1: 0 = grayscale (R=G=B=data), 1 = mono (data[0]=1 → black, else white)
- `cfg_x_i` in X_POS_W, `cfg_y_i` in Y_POS_W: top-left corner on screen
- `cfg_wlog2_i` in $clog2(IMG_AW+1): source width = 2^wlog2 pixels
- `cfg_h_i` in Y_POS_W: source height in rows
- `cfg_scale_i` in SCALE_W: upscale shift s; each source pixel covers 2^s × 2^s screen pixels
- `cfg_pending_o` out N_LAYERS: shadow configuration not yet applied, one bit per layer
- `mem_addr_o` out N_LAYERS*IMG_AW: per-layer read address
- `mem_data_i` in N_LAYERS*COLOR_W: read data, valid 1 cycle after the address
- `red_o`, `green_o`, `blue_o` out COLOR_W each: composited colour
- `hsync_o`, `vsync_o`, `de_o` out 1 each: delayed timing

## Operation
- **Shadow registers:**
  - `cfg_we_i` writes all cfg fields into the shadow set of `cfg_layer_i` and sets `cfg_pending_o[layer]`.
  - An out-of-range `cfg_layer_i` is ignored.
- **Frame-start transfer:**
  - On a vsync rising edge (vsync_i=1 while the registered previous value is 0), every layer with pending=1 copies shadow into active and clears pending.
  - If a write coincides with the edge cycle, the transfer uses the shadow contents from before that cycle. The new write is stored and stays pending for the next frame.
- **Stage 1, hit test and address** (registered):
  - Per layer: dx = pixel_x − x0 and dy = pixel_y − y0, computed in widths that cannot wrap.
  - hit = en && x ≥ x0 && x < x0 + (2^wlog2 << s) && y ≥ y0 && y < y0 + (h << s). Bounds are inclusive-start and exclusive-end; comparisons are made at widened width, so regions extending off-screen clip and never wrap.
  - sx = dx >> s, sy = dy >> s.
  - mem_addr = ((sy << wlog2) | sx), truncated to IMG_AW bits (modulo).
  - When hit=0, mem_addr holds its previous value.
- **Stage 2, memory read:**
  - hit, mode, sync and de travel alongside the read.
- **Stage 3, composite** (registered output):
  - Start from bg_color_i.
  - Scan layers 0..N_LAYERS−1; the last hitting layer overrides the colour according to its mode.
  - If the delayed de=0, RGB is forced to 0.
- Unused memory data bits above bit 0 are ignored in mono mode.

## Timing
- Latency is 3 cycles. Inputs in cycle t produce `red_o`/`green_o`/`blue_o`/`hsync_o`/`vsync_o`/`de_o` in cycle t+3.
- `mem_addr_o` is registered: the address for input cycle t is presented in cycle t+1, and data is sampled in cycle t+2.
- Throughput is one pixel per clock, with no stalls and no back-pressure.
- **Reset (`rst_ni`=0, asynchronous):**
  - All outputs, pipeline flops, `mem_addr_o` and `cfg_pending_o` go to 0.
  - Active and shadow configs are cleared, so all layers are disabled.
- **After reset release:**
  - Outputs are 0/background-gated for the first 3 cycles.
  - The first frame shows background only until layers are written and a vsync edge occurs.
- **Reset mid-frame:** the above applies immediately, with no partial-frame recovery.
- A config write between vsync edges never changes the picture of the current frame.

## Test plan
- **Bypass:** no layers, bg=0x102030, de_i=1 → RGB=10/20/30 exactly 3 cycles later; with de_i=0, RGB=0. hsync/vsync are delayed by 3 cycles.
- **Boundaries:** layer0 grayscale, x0=20, y0=20, wlog2=8, h=256, s=0. Pixel (20,20) → addr 0. Pixel (275,275) → addr 0xFFFF. Pixels (19,20) and (276,20) → background.
- **Scaling:** layer1 mono, x0=360, y0=150, wlog2=7, h=128, s=1. Pixels (360,150) and (361,151) both → addr 0. Pixel (362,150) → addr 1. mem bit0=1 gives black, 0 gives white.
- **Priority:** layers 0 and 1 overlap at (100,100) → layer1 colour wins. Disable layer1 and apply at vsync → layer0 colour.
- **Double buffering:**
  - Write layer0 x0=50 mid-frame → `cfg_pending_o[0]`=1 and the picture is unchanged until the vsync edge, after which pending=0 and the new position is used.
  - A write in the edge cycle itself stays pending for one more frame.
- **Reset:** assert `rst_ni` mid-frame → all outputs 0 immediately and layers disabled. After release, background only.
